pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the pipelined RV64I CPU.
- Replaces the fixed load-use detector and two-source forwarding selector with one block.
- A shift-register scoreboard tracks in-flight instructions from EX to WB over a configurable depth. From it the block generates forwarding selects, load-use stalls, branch flushes and multi-cycle EX holds.
- Sits beside the ID/EX pipeline buffer and drives the PC, IF/ID, ID/EX and operand-mux controls.

---
 rtl/pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for the pipelined RV64I CPU.
// A shift-register tracker follows in-flight instructions from EX (entry 0)
// to WB (entry DEPTH-1). From it the block derives operand forwarding
// selects, load-use stalls, taken-branch flushes and multi-cycle EX holds.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall/flush
// performance counters; without it those ports do not exist.
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int RB         = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [RB-1:0]              id_rs1,
  input  logic [RB-1:0]              id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [RB-1:0]              id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       ex_branch_taken,
  input  logic                       ex_busy,
  output logic                       pc_write,
  output logic                       ifid_write,
  output logic                       ifid_flush,
  output logic                       idex_bubble,
  output logic                       ex_hold,
  output logic [$clog2(DEPTH)-1:0]   fwd_a,
  output logic [$clog2(DEPTH)-1:0]   fwd_b
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_count
`endif
);

  localparam int FW = $clog2(DEPTH);

  // Tracker state: per-entry producer info, plus consumer info for entry 0.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] regwrite_q, regwrite_d;
  logic [DEPTH-1:0] memread_q, memread_d;
  logic [RB-1:0]    rd_q [DEPTH];
  logic [RB-1:0]    rd_d [DEPTH];
  logic [RB-1:0]    rs1_q, rs1_d;
  logic [RB-1:0]    rs2_q, rs2_d;
  logic             use1_q, use1_d;
  logic             use2_q, use2_d;

  logic lu;
  logic br;
  logic take_id;

  // A producer matches a consumer source only if it really writes a
  // non-zero register that the consumer really reads.
  function automatic logic src_match(input logic          v,
                                     input logic          rw,
                                     input logic [RB-1:0] rd,
                                     input logic [RB-1:0] rs,
                                     input logic          use_src);
    return v && rw && use_src && (rd == rs) && (rd != '0);
  endfunction

  // Load-use detection: a load too young to forward feeds the ID instruction.
  always_comb begin
    lu = 1'b0;
    for (int s = 0; s < LOAD_STAGE - 1; s++) begin
      if (id_valid && memread_q[s] &&
          (src_match(valid_q[s], regwrite_q[s], rd_q[s], id_rs1, id_use_rs1) ||
           src_match(valid_q[s], regwrite_q[s], rd_q[s], id_rs2, id_use_rs2))) begin
        lu = 1'b1;
      end
    end
  end

  assign br = ex_branch_taken && !ex_busy;

  // Control priority: EX hold, then taken branch, then load-use, else run.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    if (ex_busy) begin
      ex_hold    = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (br) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign take_id = id_valid && !idex_bubble;

  // Tracker next state: hold entry 0 and drain behind it while EX is busy,
  // otherwise shift everything one entry toward WB.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    use1_d     = use1_q;
    use2_d     = use2_q;
    if (ex_busy) begin
      valid_d[1]    = 1'b0;
      regwrite_d[1] = 1'b0;
      memread_d[1]  = 1'b0;
      rd_d[1]       = '0;
      for (int k = 2; k < DEPTH; k++) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        memread_d[k]  = memread_q[k-1];
        rd_d[k]       = rd_q[k-1];
      end
    end else begin
      valid_d[0]    = take_id;
      regwrite_d[0] = take_id && id_regwrite;
      memread_d[0]  = take_id && id_memread;
      rd_d[0]       = take_id ? id_rd : '0;
      rs1_d         = take_id ? id_rs1 : '0;
      rs2_d         = take_id ? id_rs2 : '0;
      use1_d        = take_id && id_use_rs1;
      use2_d        = take_id && id_use_rs2;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        memread_d[k]  = memread_q[k-1];
        rd_d[k]       = rd_q[k-1];
      end
    end
  end

  // Tracker registers; reset empties the whole pipeline view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      memread_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
      rs1_q  <= '0;
      rs2_q  <= '0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      use1_q     <= use1_d;
      use2_q     <= use2_d;
    end
  end

  // Forwarding selects: youngest matching producer wins (lowest entry index).
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (valid_q[0] && src_match(valid_q[k], regwrite_q[k], rd_q[k], rs1_q, use1_q)) begin
        fwd_a = FW'(k);
      end
      if (valid_q[0] && src_match(valid_q[k], regwrite_q[k], rd_q[k], rs2_q, use2_q)) begin
        fwd_b = FW'(k);
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating counters: PC-stalled cycles and taken-branch flush cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (br && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // Counters absent in this build; hazard control is unaffected.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of per-cycle vectors on
// the default DEPTH=3 instance, plus hand-written multi-cycle sequences and
// a DEPTH=5 / LOAD_STAGE=3 instance for the deeper load-use case.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       id_regwrite, id_memread;
  logic       ex_branch_taken, ex_busy;

  logic       pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold;
  logic [1:0] fwd_a, fwd_b;
  logic       d5_pc_write, d5_ifid_write, d5_ifid_flush, d5_idex_bubble, d5_ex_hold;
  logic [2:0] d5_fwd_a, d5_fwd_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count, d5_stall_cycles, d5_flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, br, busy;
    logic       pw, iw, fl, bub, hold;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DEPTH(3), .LOAD_STAGE(2), .RB(5)) u_dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_STAGE(3), .RB(5)) u_d5 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_write(d5_pc_write), .ifid_write(d5_ifid_write), .ifid_flush(d5_ifid_flush),
    .idex_bubble(d5_idex_bubble), .ex_hold(d5_ex_hold),
    .fwd_a(d5_fwd_a), .fwd_b(d5_fwd_b)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(d5_stall_cycles), .flush_count(d5_flush_count)
`endif
  );

  function automatic vec_t mkv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br, input logic busy,
                               input logic pw, input logic iw, input logic fl, input logic bub,
                               input logic hold, input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mr = mr; r.br = br; r.busy = busy;
    r.pw = pw; r.iw = iw; r.fl = fl; r.bub = bub; r.hold = hold; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br, input logic busy);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    ex_branch_taken = br; ex_busy = busy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic pw, input logic iw, input logic fl,
                          input logic bub, input logic hold, input logic [1:0] fa,
                          input logic [1:0] fb);
    checkOutput({tag, ".pc_write"}, 32'(pc_write), 32'(pw));
    checkOutput({tag, ".ifid_write"}, 32'(ifid_write), 32'(iw));
    checkOutput({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    checkOutput({tag, ".ex_hold"}, 32'(ex_hold), 32'(hold));
    checkOutput({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
    checkOutput({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkAll("reset", 1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset.d5_fwd_a", 32'(d5_fwd_a), 32'd0);
    checkOutput("reset.d5_pc_write", 32'(d5_pc_write), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("reset.stall_cycles", stall_cycles, 32'd0);
    checkOutput("reset.flush_count", flush_count, 32'd0);
`endif
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // Table: each row is one cycle; expected outputs are the combinational
    // controls seen before that cycle's edge (DEPTH=3, LOAD_STAGE=2).
    //                v  rs1 rs2 u1 u2 rd rw mr br bz  pw iw fl bb hd fa fb
    vecs.push_back(mkv(1,  1,  2, 1, 1, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // add x5
    vecs.push_back(mkv(1,  5,  7, 1, 1, 6, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // sub x6,x5,x7
    vecs.push_back(mkv(1,  1,  2, 1, 1, 8, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0)); // or x8 ; sub gets fwd 1
    vecs.push_back(mkv(1,  6,  8, 1, 1, 9, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // and x9,x6,x8
    vecs.push_back(mkv(0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 1)); // and: x6 at 2, x8 at 1
    vecs.push_back(mkv(1,  1,  0, 1, 0,11, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // addi x11
    vecs.push_back(mkv(1,  1,  0, 1, 0,11, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // addi x11 again
    vecs.push_back(mkv(1, 11, 11, 1, 0,12, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // rs2 unused
    vecs.push_back(mkv(0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0)); // youngest wins, use2 gates
    vecs.push_back(mkv(0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1,  1,  0, 1, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // ld x0
    vecs.push_back(mkv(1,  0,  0, 1, 1,13, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // x0 reader: no stall
    vecs.push_back(mkv(0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // x0: no forward
    vecs.push_back(mkv(1,  1,  0, 1, 0, 5, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // ld x5
    vecs.push_back(mkv(1,  5,  5, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // load-use stall
    vecs.push_back(mkv(1,  5,  5, 1, 1, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // retry: no stall
    vecs.push_back(mkv(0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 2)); // load forwarded from 2

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                    vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].br, vecs[i].busy);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].pw, vecs[i].iw, vecs[i].fl,
               vecs[i].bub, vecs[i].hold, vecs[i].fa, vecs[i].fb);
    end

    // Load-use coinciding with a taken branch: branch wins, no stall after.
    doReset();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); #1;
    checkAll("lubr.ld", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 5, 0, 1, 0, 7, 1, 0, 1, 0); #1;
    checkAll("lubr.both", 1, 1, 1, 1, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 5, 0, 1, 0, 9, 1, 0, 0, 0); #1;
    checkAll("lubr.after", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); idle(); #1;
    checkAll("lubr.fwd", 1, 1, 0, 0, 0, 2, 0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("lubr.flush_count", flush_count, 32'd1);
    checkOutput("lubr.stall_cycles", stall_cycles, 32'd0);
`endif

    // Multi-cycle EX: four busy cycles hold EX and drain entries behind it.
    doReset();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 5, 1, 0, 0, 0); #1;
    checkAll("busy.add", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 5, 7, 1, 1, 6, 1, 0, 0, 0); #1;
    checkAll("busy.sub", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); applyStimulus(1, 6, 5, 1, 1, 8, 1, 0, 0, 1); #1;
      checkOutput($sformatf("busy%0d.ex_hold", i), 32'(ex_hold), 32'd1);
      checkOutput($sformatf("busy%0d.pc_write", i), 32'(pc_write), 32'd0);
      checkOutput($sformatf("busy%0d.ifid_write", i), 32'(ifid_write), 32'd0);
      checkOutput($sformatf("busy%0d.idex_bubble", i), 32'(idex_bubble), 32'd0);
      checkOutput($sformatf("busy%0d.ifid_flush", i), 32'(ifid_flush), 32'd0);
    end
    @(negedge clk); applyStimulus(1, 6, 5, 1, 1, 8, 1, 0, 0, 0); #1;
    checkAll("busy.drained", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); idle(); #1;
    checkAll("busy.held", 1, 1, 0, 0, 0, 1, 0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("busy.stall_cycles", stall_cycles, 32'd4);
`endif

    // Asynchronous reset mid-stream while a load-use stall is active.
    doReset();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 5, 1, 0, 0, 0); #1;
    checkAll("rst.add", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 5, 0, 1, 0, 6, 1, 1, 0, 0); #1;
    checkAll("rst.ld", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(1, 6, 0, 1, 0, 9, 1, 0, 0, 0); #1;
    checkAll("rst.pre", 0, 0, 0, 1, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    checkAll("rst.async", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; #1;
    checkAll("rst.release", 1, 1, 0, 0, 0, 0, 0);

    // DEPTH=5, LOAD_STAGE=3: a load in EX costs two bubbles, then fwd 3.
    doReset();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); #1;
    checkOutput("d5.ld.pc_write", 32'(d5_pc_write), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); applyStimulus(1, 5, 0, 1, 0, 7, 1, 0, 0, 0); #1;
      checkOutput($sformatf("d5.stall%0d.pc_write", i), 32'(d5_pc_write), 32'd0);
      checkOutput($sformatf("d5.stall%0d.ifid_write", i), 32'(d5_ifid_write), 32'd0);
      checkOutput($sformatf("d5.stall%0d.idex_bubble", i), 32'(d5_idex_bubble), 32'd1);
    end
    @(negedge clk); applyStimulus(1, 5, 0, 1, 0, 7, 1, 0, 0, 0); #1;
    checkOutput("d5.go.pc_write", 32'(d5_pc_write), 32'd1);
    checkOutput("d5.go.idex_bubble", 32'(d5_idex_bubble), 32'd0);
    @(negedge clk); idle(); #1;
    checkOutput("d5.fwd_a", 32'(d5_fwd_a), 32'd3);
    checkOutput("d5.fwd_b", 32'(d5_fwd_b), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("d5.stall_cycles", d5_stall_cycles, 32'd2);
    checkOutput("d5.flush_count", d5_flush_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
